// File: rtl/studio2_pkg.sv
// Shared types and header layout constants for the Studio II cartridge loader.
package studio2_pkg;

    typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_e;

    localparam logic [31:0] ST2_MAGIC      = 32'h52434132; // "RCA2", offset 0 first
    localparam int unsigned HDR_OFS_COUNT  = 4;
    localparam int unsigned HDR_OFS_TABLE  = 64;
    localparam int unsigned HDR_OFS_DATA   = 256;
    localparam int unsigned HDR_OFS_LAST   = HDR_OFS_DATA - 1;

    localparam logic [5:0]  CART_SLOT      = 6'd1;
    localparam logic [1:0]  EXT_BIN        = 2'd0;
    localparam logic [1:0]  EXT_ST2        = 2'd1;

endpackage

// File: rtl/cart_loader_if.sv
// Download, CPU and cartridge-RAM signals of the loader; slave is the loader side.
interface cart_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] cpu_addr;
  logic        cpu_rd;
  logic        cpu_grant;
  logic [15:0] mem_addr;
  logic [7:0]  mem_din;
  logic        mem_we;
  logic        busy;
  logic        cart_valid;
  logic        hdr_error;

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, cpu_addr, cpu_rd,
    output cpu_grant, mem_addr, mem_din, mem_we, busy, cart_valid, hdr_error
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, cpu_addr, cpu_rd,
    input  cpu_grant, mem_addr, mem_din, mem_we, busy, cart_valid, hdr_error
  );
endinterface

// File: rtl/st2_page_table.sv
// st2 block -> RAM page map; synchronous write, combinational read, cleared on reset.
module st2_page_table #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [7:0]       rdata_o
);
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : 8'h00;
endmodule

// File: rtl/cart_loader.sv
// Parses bin/st2 cartridge downloads into cartridge RAM; writes land one cycle after ioctl_wr.
// Loader writes always own the RAM port; the CPU is granted only when idle with no write pending.
module cart_loader
  import studio2_pkg::*;
#(
  parameter logic [15:0] RAW_BASE   = 16'h0400,
  parameter int unsigned MAX_BLOCKS = 64
) (
  input logic          clk,
  input logic          reset,
  cart_loader_if.slave bus
);
  localparam int unsigned IDX_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;

  state_e      state_q, state_d;
  logic        dl_q;
  logic        st2_q, st2_d;
  logic [31:0] magic_q, magic_d;
  logic [7:0]  count_q, count_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [15:0] waddr_q, waddr_d;
  logic [7:0]  wdat_q, wdat_d;

  logic             pt_we;
  logic [7:0]       pt_rdata;
  logic [24:0]      a;
  logic [24:0]      tbl_ofs;
  logic [16:0]      blk;
  logic [1:0]       ext;
  logic             dl_rise, dl_fall, hdr_ok, in_tbl, in_blk;
  logic             unused_cpu_rd;

  assign a             = bus.ioctl_addr;
  assign ext           = bus.ioctl_index[7:6];
  assign dl_rise       = bus.ioctl_download & ~dl_q;
  assign dl_fall       = ~bus.ioctl_download & dl_q;
  assign tbl_ofs       = a - 25'(HDR_OFS_TABLE);
  assign blk           = a[24:8] - 17'd1;
  assign hdr_ok        = (magic_q == ST2_MAGIC) && (count_q != 8'd0) && (32'(count_q) <= MAX_BLOCKS);
  assign in_tbl        = (a >= 25'(HDR_OFS_TABLE)) && (tbl_ofs < 25'(count_q)) &&
                         (tbl_ofs < 25'(MAX_BLOCKS));
  assign in_blk        = (a >= 25'(HDR_OFS_DATA)) && (blk < 17'(count_q));
  assign unused_cpu_rd = bus.cpu_rd;

  st2_page_table #(.DEPTH(MAX_BLOCKS), .IDX_W(IDX_W)) u_page_table (
    .clk     (clk),
    .reset   (reset),
    .we_i    (pt_we),
    .waddr_i (tbl_ofs[IDX_W-1:0]),
    .wdata_i (bus.ioctl_dout),
    .raddr_i (blk[IDX_W-1:0]),
    .rdata_o (pt_rdata)
  );

  always_comb begin
    state_d = state_q;
    st2_d   = st2_q;
    magic_d = magic_q;
    count_d = count_q;
    valid_d = valid_q;
    err_d   = err_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdat_d  = wdat_q;
    pt_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (dl_rise && bus.ioctl_index[5:0] == CART_SLOT && (ext == EXT_BIN || ext == EXT_ST2)) begin
          st2_d   = (ext == EXT_ST2);
          state_d = (ext == EXT_ST2) ? HDR : DATA;
          magic_d = '0;
          count_d = '0;
          valid_d = 1'b0;
          err_d   = 1'b0;
        end
      end
      HDR: begin
        if (bus.ioctl_wr) begin
          if (a < 25'(HDR_OFS_COUNT)) begin
            case (a[1:0])
              2'd0: magic_d[31:24] = bus.ioctl_dout;
              2'd1: magic_d[23:16] = bus.ioctl_dout;
              2'd2: magic_d[15:8]  = bus.ioctl_dout;
              2'd3: magic_d[7:0]   = bus.ioctl_dout;
            endcase
          end
          if (a == 25'(HDR_OFS_COUNT)) count_d = bus.ioctl_dout;
          pt_we = in_tbl;
        end
        // A final header byte arriving with the fall is committed before the fall is honoured.
        if (bus.ioctl_wr && a == 25'(HDR_OFS_LAST)) begin
          if (!hdr_ok) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d = dl_fall ? DONE : DATA;
          end
        end else if (dl_fall) begin
          state_d = ERR;
          err_d   = 1'b1;
        end
      end
      DATA: begin
        if (bus.ioctl_wr) begin
          if (!st2_q) begin
            we_d    = 1'b1;
            waddr_d = RAW_BASE + a[15:0];
            wdat_d  = bus.ioctl_dout;
          end else if (in_blk) begin
            we_d    = 1'b1;
            waddr_d = {pt_rdata, a[7:0]};
            wdat_d  = bus.ioctl_dout;
          end
        end
        if (dl_fall) state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        valid_d = 1'b0;
        if (!bus.ioctl_download) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // dl_q keeps tracking through reset so an aborted download cannot restart itself.
  always_ff @(posedge clk) begin
    dl_q <= bus.ioctl_download;
    if (reset) begin
      state_q <= IDLE;
      st2_q   <= 1'b0;
      magic_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      st2_q   <= st2_d;
      magic_q <= magic_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdat_q  <= wdat_d;
    end
  end

  assign bus.busy       = (state_q == HDR) || (state_q == DATA);
  assign bus.cpu_grant  = ~bus.busy & ~we_q;
  assign bus.mem_we     = we_q;
  assign bus.mem_addr   = we_q ? waddr_q : bus.cpu_addr;
  assign bus.mem_din    = wdat_q;
  assign bus.cart_valid = valid_q;
  assign bus.hdr_error  = err_q;
endmodule
